instr_register_mc: RTL and testbench



---
 rtl/instr_register_pkg.sv | 30 +++
 rtl/iter_divpow.sv | 138 +++++++++++++
 rtl/instr_register_mc.sv | 183 ++++++++++++++++++
 tb/tb_instr_register_mc.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_register_pkg.sv
// Shared types for the multi-cycle instruction register: opcodes, commit
// status codes and the control FSM encoding.
package instr_register_pkg;

  typedef enum logic [3:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7,
    POW   = 4'd8
  } opcode_t;

  typedef enum logic [1:0] {
    OK      = 2'd0,
    DIV0    = 2'd1,
    NEG_EXP = 2'd2,
    ILLEGAL = 2'd3
  } instr_status_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_COMMIT = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/iter_divpow.sv
// Iterative engine shared by DIV/MOD (restoring division on magnitudes) and
// POW (MSB-first square-and-multiply). One iteration per cycle, OP_W cycles
// after start; `last` flags the final iteration, and the sign-fixed result
// is valid from the cycle after `last` until the next start.
module iter_divpow #(
  parameter int OP_W  = 32,
  parameter int RES_W = 2 * OP_W
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   is_pow,
  input  logic                   is_mod,
  input  logic signed [OP_W-1:0] a,
  input  logic signed [OP_W-1:0] b,
  output logic                   last,
  output logic [RES_W-1:0]       result
);

  localparam int CNT_W = $clog2(OP_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OP_W - 1);

  logic             run_q, run_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pow_q, pow_d;
  logic             mod_q, mod_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic [OP_W-1:0]  rem_q, rem_d;
  logic [OP_W-1:0]  quo_q, quo_d;
  logic [OP_W-1:0]  dvs_q, dvs_d;
  logic [RES_W-1:0] acc_q, acc_d;
  logic [RES_W-1:0] base_q, base_d;
  logic [OP_W-1:0]  exp_q, exp_d;

  logic [OP_W:0]    rem_sh;
  logic [RES_W-1:0] acc_sq;
  logic [OP_W-1:0]  mag_a, mag_b;
  logic [RES_W-1:0] quo_ext, rem_ext;

  // Next-state: load magnitudes/base on start, otherwise run one iteration
  always_comb begin
    mag_a  = a[OP_W-1] ? OP_W'(-a) : OP_W'(a);
    mag_b  = b[OP_W-1] ? OP_W'(-b) : OP_W'(b);
    rem_sh = {rem_q, quo_q[OP_W-1]};
    acc_sq = acc_q * acc_q;

    run_d  = run_q;
    cnt_d  = cnt_q;
    pow_d  = pow_q;
    mod_d  = mod_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    acc_d  = acc_q;
    base_d = base_q;
    exp_d  = exp_q;

    if (start) begin
      run_d  = 1'b1;
      cnt_d  = '0;
      pow_d  = is_pow;
      mod_d  = is_mod;
      qneg_d = a[OP_W-1] ^ b[OP_W-1];
      rneg_d = a[OP_W-1];
      rem_d  = '0;
      quo_d  = mag_a;
      dvs_d  = mag_b;
      acc_d  = RES_W'(1);
      base_d = {{(RES_W-OP_W){a[OP_W-1]}}, a};
      exp_d  = b;
    end else if (run_q) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_LAST) begin
        run_d = 1'b0;
      end
      if (pow_q) begin
        // Products wrap to RES_W; overflow is silently truncated
        acc_d = exp_q[OP_W-1] ? acc_sq * base_q : acc_sq;
        exp_d = {exp_q[OP_W-2:0], 1'b0};
      end else if (rem_sh >= {1'b0, dvs_q}) begin
        rem_d = rem_sh[OP_W-1:0] - dvs_q;
        quo_d = {quo_q[OP_W-2:0], 1'b1};
      end else begin
        rem_d = rem_sh[OP_W-1:0];
        quo_d = {quo_q[OP_W-2:0], 1'b0};
      end
    end
  end

  // Engine registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q  <= 1'b0;
      cnt_q  <= '0;
      pow_q  <= 1'b0;
      mod_q  <= 1'b0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      acc_q  <= '0;
      base_q <= '0;
      exp_q  <= '0;
    end else begin
      run_q  <= run_d;
      cnt_q  <= cnt_d;
      pow_q  <= pow_d;
      mod_q  <= mod_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      acc_q  <= acc_d;
      base_q <= base_d;
      exp_q  <= exp_d;
    end
  end

  // Sign fix: quotient truncates toward zero, remainder follows A
  always_comb begin
    quo_ext = {{(RES_W-OP_W){1'b0}}, quo_q};
    rem_ext = {{(RES_W-OP_W){1'b0}}, rem_q};
    last    = run_q && (cnt_q == CNT_LAST);
    if (pow_q) begin
      result = acc_q;
    end else if (mod_q) begin
      result = rneg_q ? -rem_ext : rem_ext;
    end else begin
      result = qneg_q ? -quo_ext : quo_ext;
    end
  end

endmodule

// File: rtl/instr_register_mc.sv
// Multi-cycle instruction register: accepts {opcode, A, B} on a valid/ready
// handshake, computes the result (single-cycle datapath or iterative engine)
// and commits the whole instruction plus status into a DEPTH-entry array
// with combinational read.
module instr_register_mc
  import instr_register_pkg::*;
#(
  parameter int OP_W  = 32,
  parameter int DEPTH = 32,
  parameter int RES_W = 2 * OP_W
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     load_valid,
  output logic                     load_ready,
  input  opcode_t                  opcode,
  input  logic signed [OP_W-1:0]   operand_a,
  input  logic signed [OP_W-1:0]   operand_b,
  input  logic [$clog2(DEPTH)-1:0] write_pointer,
  input  logic [$clog2(DEPTH)-1:0] read_pointer,
  output opcode_t                  rd_opcode,
  output logic signed [OP_W-1:0]   rd_operand_a,
  output logic signed [OP_W-1:0]   rd_operand_b,
  output logic signed [RES_W-1:0]  rd_result,
  output instr_status_t            rd_status,
  output logic                     rd_valid,
  output logic                     busy,
  output logic                     done
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    opcode_t                 op;
    logic signed [OP_W-1:0]  a;
    logic signed [OP_W-1:0]  b;
    logic signed [RES_W-1:0] res;
    instr_status_t           st;
  } rec_t;

  localparam rec_t REC_RST = '{op: ZERO, a: '0, b: '0, res: '0, st: OK};

  ctrl_state_t   state_q, state_d;
  logic          done_q, done_d;
  rec_t          pend_q, pend_d;
  logic [AW-1:0] pend_wp_q, pend_wp_d;

  rec_t             mem_q [DEPTH];
  logic [DEPTH-1:0] valid_q;

  logic                    accept;
  logic                    multi;
  logic signed [RES_W-1:0] a_ext, b_ext;
  logic signed [RES_W-1:0] sc_res;
  instr_status_t           sc_st;
  logic                    wr_en;
  logic [AW-1:0]           wr_idx;
  rec_t                    wr_rec;
  logic                    eng_start;
  logic                    eng_last;
  logic [RES_W-1:0]        eng_result;

  iter_divpow #(
    .OP_W  (OP_W),
    .RES_W (RES_W)
  ) u_engine (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (eng_start),
    .is_pow  (opcode == POW),
    .is_mod  (opcode == MOD),
    .a       (operand_a),
    .b       (operand_b),
    .last    (eng_last),
    .result  (eng_result)
  );

  // Single-cycle datapath and routing decision for the presented opcode
  always_comb begin
    a_ext  = {{(RES_W-OP_W){operand_a[OP_W-1]}}, operand_a};
    b_ext  = {{(RES_W-OP_W){operand_b[OP_W-1]}}, operand_b};
    sc_res = '0;
    sc_st  = OK;
    multi  = 1'b0;
    case (opcode)
      ZERO:    sc_res = '0;
      PASSA:   sc_res = a_ext;
      PASSB:   sc_res = b_ext;
      ADD:     sc_res = a_ext + b_ext;
      SUB:     sc_res = a_ext - b_ext;
      MULT:    sc_res = a_ext * b_ext;
      DIV, MOD: begin
        if (operand_b == '0) sc_st = DIV0;
        else                 multi = 1'b1;
      end
      POW: begin
        if (operand_b[OP_W-1]) sc_st = NEG_EXP;
        else                   multi = 1'b1;
      end
      default: sc_st = ILLEGAL;
    endcase
  end

  // Control FSM next state: single-cycle ops commit at the accept edge,
  // engine ops go RUN -> COMMIT and write from the pending record
  always_comb begin
    accept    = load_valid && (state_q == ST_IDLE);
    state_d   = state_q;
    done_d    = 1'b0;
    pend_d    = pend_q;
    pend_wp_d = pend_wp_q;
    eng_start = 1'b0;
    wr_en     = 1'b0;
    wr_idx    = write_pointer;
    wr_rec    = '{op: opcode, a: operand_a, b: operand_b, res: sc_res, st: sc_st};
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (multi) begin
            state_d   = ST_RUN;
            eng_start = 1'b1;
            pend_d    = '{op: opcode, a: operand_a, b: operand_b, res: '0, st: OK};
            pend_wp_d = write_pointer;
          end else begin
            wr_en  = 1'b1;
            done_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (eng_last) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        wr_en      = 1'b1;
        wr_idx     = pend_wp_q;
        wr_rec     = pend_q;
        wr_rec.res = eng_result;
        done_d     = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      done_q    <= 1'b0;
      pend_q    <= REC_RST;
      pend_wp_q <= '0;
    end else begin
      state_q   <= state_d;
      done_q    <= done_d;
      pend_q    <= pend_d;
      pend_wp_q <= pend_wp_d;
    end
  end

  // Storage array; every entry returns to the reset record on reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= REC_RST;
      end
      valid_q <= '0;
    end else if (wr_en) begin
      mem_q[wr_idx]   <= wr_rec;
      valid_q[wr_idx] <= 1'b1;
    end
  end

  assign rd_opcode    = mem_q[read_pointer].op;
  assign rd_operand_a = mem_q[read_pointer].a;
  assign rd_operand_b = mem_q[read_pointer].b;
  assign rd_result    = mem_q[read_pointer].res;
  assign rd_status    = mem_q[read_pointer].st;
  assign rd_valid     = valid_q[read_pointer];
  assign busy         = (state_q != ST_IDLE);
  assign load_ready   = (state_q == ST_IDLE);
  assign done         = done_q;

endmodule

// File: tb/tb_instr_register_mc.sv
// Randomised and directed bench for instr_register_mc against a plain
// arithmetic reference model of the instruction semantics.
module tb_instr_register_mc;
  import instr_register_pkg::*;

  localparam int OP_W  = 32;
  localparam int DEPTH = 32;
  localparam int RES_W = 64;
  localparam int AW    = 5;

  logic                    clk = 1'b0;
  logic                    reset_n = 1'b1;
  logic                    load_valid = 1'b0;
  logic                    load_ready;
  opcode_t                 opcode = ZERO;
  logic signed [OP_W-1:0]  operand_a = '0;
  logic signed [OP_W-1:0]  operand_b = '0;
  logic [AW-1:0]           write_pointer = '0;
  logic [AW-1:0]           read_pointer = '0;
  opcode_t                 rd_opcode;
  logic signed [OP_W-1:0]  rd_operand_a;
  logic signed [OP_W-1:0]  rd_operand_b;
  logic signed [RES_W-1:0] rd_result;
  instr_status_t           rd_status;
  logic                    rd_valid;
  logic                    busy;
  logic                    done;

  instr_register_mc #(.OP_W(OP_W), .DEPTH(DEPTH), .RES_W(RES_W)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .load_valid    (load_valid),
    .load_ready    (load_ready),
    .opcode        (opcode),
    .operand_a     (operand_a),
    .operand_b     (operand_b),
    .write_pointer (write_pointer),
    .read_pointer  (read_pointer),
    .rd_opcode     (rd_opcode),
    .rd_operand_a  (rd_operand_a),
    .rd_operand_b  (rd_operand_b),
    .rd_result     (rd_result),
    .rd_status     (rd_status),
    .rd_valid      (rd_valid),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference memory image
  logic [3:0] m_op  [DEPTH];
  int         m_a   [DEPTH];
  int         m_b   [DEPTH];
  longint     m_res [DEPTH];
  logic [1:0] m_st  [DEPTH];
  bit         m_v   [DEPTH];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_op[i] = 4'd0; m_a[i] = 0; m_b[i] = 0; m_res[i] = 0; m_st[i] = 2'd0; m_v[i] = 1'b0;
    end
  endtask

  task automatic model_write(input int wp, input logic [3:0] op, input int a, input int b,
                             input longint r, input logic [1:0] st);
    m_op[wp] = op; m_a[wp] = a; m_b[wp] = b; m_res[wp] = r; m_st[wp] = st; m_v[wp] = 1'b1;
  endtask

  // Instruction semantics from the rules: status codes OK=0 DIV0=1 NEG_EXP=2 ILLEGAL=3
  task automatic ref_calc(input logic [3:0] op, input int a, input int b,
                          output longint r, output logic [1:0] st, output bit multi);
    r = 0; st = 2'd0; multi = 1'b0;
    case (op)
      4'd0: r = 0;
      4'd1: r = a;
      4'd2: r = b;
      4'd3: r = longint'(a) + longint'(b);
      4'd4: r = longint'(a) - longint'(b);
      4'd5: r = longint'(a) * longint'(b);
      4'd6: if (b == 0) st = 2'd1; else begin r = longint'(a) / longint'(b); multi = 1'b1; end
      4'd7: if (b == 0) st = 2'd1; else begin r = longint'(a) % longint'(b); multi = 1'b1; end
      4'd8: if (b < 0) st = 2'd2;
            else begin
              r = 1;
              for (int i = 0; i < b; i++) r = r * longint'(a);
              multi = 1'b1;
            end
      default: st = 2'd3;
    endcase
  endtask

  task automatic read_chk(input int idx, input string tag);
    read_pointer = AW'(idx);
    #1;
    check($sformatf("%s.op[%0d]", tag, idx), rd_opcode, m_op[idx]);
    check($sformatf("%s.a[%0d]", tag, idx), rd_operand_a, m_a[idx]);
    check($sformatf("%s.b[%0d]", tag, idx), rd_operand_b, m_b[idx]);
    check($sformatf("%s.res[%0d]", tag, idx), rd_result, m_res[idx]);
    check($sformatf("%s.st[%0d]", tag, idx), rd_status, m_st[idx]);
    check($sformatf("%s.valid[%0d]", tag, idx), rd_valid, m_v[idx]);
  endtask

  task automatic check_res(input int idx, input string tag, input longint r, input logic [1:0] st);
    read_pointer = AW'(idx);
    #1;
    check({tag, ".res"}, rd_result, r);
    check({tag, ".st"}, rd_status, st);
  endtask

  // Present an instruction (call between negedge and posedge), hold it until
  // accepted; waited = negedges spent with load_ready low
  task automatic do_load(input logic [3:0] op, input int a, input int b, input int wp,
                         output int waited);
    opcode = opcode_t'(op); operand_a = a; operand_b = b; write_pointer = AW'(wp);
    load_valid = 1'b1;
    waited = 0;
    while (!load_ready && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    opcode = opcode_t'(4'($urandom)); operand_a = $urandom; operand_b = $urandom;
    write_pointer = AW'($urandom);
  endtask

  task automatic run_txn(input logic [3:0] op, input int a, input int b, input int wp);
    longint r; logic [1:0] st; bit multi; int waited; int busy_cnt;
    ref_calc(op, a, b, r, st, multi);
    do_load(op, a, b, wp, waited);
    check("ready_wait", waited, 0);
    @(negedge clk);
    if (!multi) begin
      check("sc_done", done, 1'b1);
      check("sc_busy", busy, 1'b0);
      model_write(wp, op, a, b, r, st);
      read_chk(wp, "sc");
    end else begin
      read_pointer = AW'(wp);
      #1;
      check("hold_old_res", rd_result, m_res[wp]);
      check("hold_old_valid", rd_valid, m_v[wp]);
      busy_cnt = 0;
      while (busy && busy_cnt < 200) begin
        busy_cnt++;
        @(negedge clk);
      end
      check("mc_latency", busy_cnt, OP_W + 1);
      check("mc_done", done, 1'b1);
      model_write(wp, op, a, b, r, st);
      read_chk(wp, "mc");
      @(negedge clk);
      check("mc_done_low", done, 1'b0);
    end
    $display("txn op=%0d a=%0d b=%0d wp=%0d exp_res=%0d exp_st=%0d", op, a, b, wp, r, st);
  endtask

  initial begin
    int waited, waited2, done_seen;
    longint r1, r2; logic [1:0] s1, s2; bit mu;
    logic [3:0] op; int a, b, wp;

    model_reset();
    #2 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", load_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    for (int i = 0; i < DEPTH; i++) read_chk(i, "rst");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Back-to-back single-cycle ops on consecutive edges
    run_txn(4'd3, 7, -3, 0);
    run_txn(4'd4, 5, 9, 1);
    run_txn(4'd5, -4, 6, 2);
    check_res(0, "add", 4, 2'd0);
    check_res(1, "sub", -4, 2'd0);
    check_res(2, "mult", -24, 2'd0);
    @(negedge clk);
    check("b2b_done_low", done, 1'b0);

    // Engine ops
    run_txn(4'd6, -17, 5, 3);
    check_res(3, "div", -3, 2'd0);
    run_txn(4'd7, -17, 5, 6);
    check_res(6, "mod", -2, 2'd0);

    // A request held during busy is taken only after the commit
    ref_calc(4'd6, 100, -7, r1, s1, mu);
    ref_calc(4'd3, 100, 23, r2, s2, mu);
    do_load(4'd6, 100, -7, 7, waited);
    @(negedge clk);
    do_load(4'd3, 100, 23, 8, waited2);
    check("held_wait", waited2, OP_W + 1);
    @(negedge clk);
    check("held_done", done, 1'b1);
    model_write(7, 4'd6, 100, -7, r1, s1);
    model_write(8, 4'd3, 100, 23, r2, s2);
    read_chk(7, "held_div");
    read_chk(8, "held_add");
    check_res(7, "div_neg", -14, 2'd0);

    // Boundary cases
    run_txn(4'd6, 9, 0, 9);
    check_res(9, "div0", 0, 2'd1);
    run_txn(4'd8, 3, 4, 10);
    check_res(10, "pow34", 81, 2'd0);
    run_txn(4'd8, 2, 0, 11);
    check_res(11, "pow20", 1, 2'd0);
    run_txn(4'd8, 2, -1, 12);
    check_res(12, "pow_neg", 0, 2'd2);
    run_txn(4'd12, 5, 6, 13);
    check_res(13, "illegal", 0, 2'd3);
    run_txn(4'd8, 2, 2 * OP_W, 14);
    check_res(14, "pow_ovf", 0, 2'd0);

    // Reset in the middle of a DIV: no commit, no done, entry cleared
    run_txn(4'd3, 1, 1, 5);
    do_load(4'd6, 1000, 3, 5, waited);
    repeat (5) @(negedge clk);
    check("mid_busy", busy, 1'b1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_ready", load_ready, 1'b1);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    done_seen = 0;
    repeat (OP_W + 4) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("mid_no_done", done_seen, 0);
    check("mid_ready", load_ready, 1'b1);
    read_chk(5, "mid");

    // Randomised traffic
    for (int n = 0; n < 40; n++) begin
      op = 4'($urandom_range(0, 11));
      if (op > 4'd8) op = 4'($urandom_range(9, 15));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 1) == 1) a = int'($urandom_range(0, 200)) - 100;
      if ($urandom_range(0, 1) == 1) b = int'($urandom_range(0, 200)) - 100;
      if ((op == 4'd6 || op == 4'd7) && $urandom_range(0, 5) == 0) b = 0;
      if (op == 4'd8) b = int'($urandom_range(0, 75)) - 5;
      wp = int'($urandom_range(0, DEPTH - 1));
      run_txn(op, a, b, wp);
    end
    for (int i = 0; i < DEPTH; i++) read_chk(i, "final");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
